// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// State encoding, instruction size and default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    PRESENT,
    HALT
  } state_t;

  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Next fetch address: sequential step or branch target.
// Branch targets are forced to word alignment.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  logic [XLEN-1:0] target;

  // Redirect target wraps silently; low bits are dropped.
  always_comb begin
    target   = branch_pc + branch_offset;
    misalign = branch && (target[1:0] != 2'b00);
    if (branch) begin
      next_pc = {target[XLEN-1:2], 2'b00};
    end else begin
      next_pc = pc + XLEN'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC and issues one
// memory request at a time, with redirect, stall and halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               stall,
  input  logic               branch,
  input  logic [XLEN-1:0]    branch_pc,
  input  logic [XLEN-1:0]    branch_offset,
  input  logic               finish_flag,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic [XLEN-1:0]    pc,
  output logic               misalign,
  output logic               halted
);

  state_t state_q, state_d;

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               req_q, req_d;
  logic               ivld_q, ivld_d;
  logic               mis_q, mis_d;
  logic               halt_q, halt_d;
  logic               flush_q, flush_d;
  logic               hold_req;

  logic [XLEN-1:0] npc;
  logic            npc_mis;

  next_pc_calc #(
    .XLEN(XLEN)
  ) u_npc (
    .pc           (pc_q),
    .branch       (branch),
    .branch_pc    (branch_pc),
    .branch_offset(branch_offset),
    .next_pc      (npc),
    .misalign     (npc_mis)
  );

  // Next state and next register values.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ipc_d    = ipc_q;
    instr_d  = instr_q;
    ivld_d   = ivld_q;
    flush_d  = flush_q;
    mis_d    = 1'b0;
    hold_req = 1'b0;
    if (finish_flag) begin
      state_d = HALT;
      ivld_d  = 1'b0;
      flush_d = 1'b0;
    end else begin
      unique case (state_q)
        REQ: begin
          if (branch) begin
            pc_d     = npc;
            mis_d    = npc_mis;
            hold_req = 1'b1;
          end else if (req_q && imem_req_ready) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (branch) begin
            pc_d  = npc;
            mis_d = npc_mis;
            if (imem_resp_valid) begin
              flush_d = 1'b0;
              state_d = REQ;
            end else begin
              flush_d = 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (flush_q) begin
              flush_d = 1'b0;
              state_d = REQ;
            end else begin
              instr_d = imem_resp_data;
              ipc_d   = pc_q;
              ivld_d  = 1'b1;
              state_d = PRESENT;
            end
          end
        end
        PRESENT: begin
          if (branch) begin
            pc_d    = npc;
            mis_d   = npc_mis;
            ivld_d  = 1'b0;
            state_d = REQ;
          end else if (!stall) begin
            pc_d    = npc;
            ivld_d  = 1'b0;
            state_d = REQ;
          end
        end
        HALT: begin
          ivld_d = 1'b0;
        end
      endcase
    end
    req_d  = (state_d == REQ) && !hold_req;
    halt_d = (state_d == HALT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      instr_q <= '0;
      req_q   <= 1'b0;
      ivld_q  <= 1'b0;
      mis_q   <= 1'b0;
      halt_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      ivld_q  <= ivld_d;
      mis_q   <= mis_d;
      halt_q  <= halt_d;
      flush_q <= flush_d;
    end
  end

  assign imem_req_valid = req_q;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign instr_valid    = ivld_q;
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign misalign       = mis_q;
  assign halted         = halt_q;

endmodule
